// File: rtl/wash_heater_ctrl_pkg.sv
// Shared definitions for the wash heater controller: phase encodings,
// one-hot temperature codes, the temperature width and small helpers.
package wash_heater_ctrl_pkg;

    localparam int TEMP_W = 7;

    localparam logic [2:0] PH_IDLE  = 3'd0;
    localparam logic [2:0] PH_FILL  = 3'd1;
    localparam logic [2:0] PH_HEAT  = 3'd2;
    localparam logic [2:0] PH_HOLD  = 3'd3;
    localparam logic [2:0] PH_DONE  = 3'd4;
    localparam logic [2:0] PH_FAULT = 3'd5;

    localparam logic [2:0] SEL_HOT  = 3'b001;
    localparam logic [2:0] SEL_WARM = 3'b010;
    localparam logic [2:0] SEL_COLD = 3'b100;

    // Map a selector code to its target; anything not one-hot-legal falls back to warm.
    function automatic logic [TEMP_W-1:0] map_target(
        input logic [2:0]        code,
        input logic [TEMP_W-1:0] t_hot,
        input logic [TEMP_W-1:0] t_warm,
        input logic [TEMP_W-1:0] t_cold
    );
        logic [TEMP_W-1:0] t;
        case (code)
            SEL_HOT:  t = t_hot;
            SEL_WARM: t = t_warm;
            SEL_COLD: t = t_cold;
            default:  t = t_warm;
        endcase
        return t;
    endfunction

    // Add with saturation at the top of the temperature range.
    function automatic logic [TEMP_W-1:0] sat_add(
        input logic [TEMP_W-1:0] a,
        input logic [TEMP_W-1:0] b
    );
        logic [TEMP_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[TEMP_W] ? {TEMP_W{1'b1}} : sum[TEMP_W-1:0];
    endfunction

endpackage

// File: rtl/wash_heater_ctrl_water_model.sv
// Water temperature accumulator: heats by HEAT_STEP per tick while the
// heater is on, otherwise cools 1 degree every COOL_DIV ticks down to AMBIENT.
module wash_water_model
    import wash_heater_ctrl_pkg::*;
#(
    parameter int AMBIENT   = 20,
    parameter int HEAT_STEP = 1,
    parameter int COOL_DIV  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              load,
    input  logic              heat,
    output logic [TEMP_W-1:0] water_temp
);

    logic [TEMP_W-1:0] temp_r;
    logic [7:0]        cool_cnt_r;

    // Temperature and cooling prescaler; any heating tick restarts the prescaler.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            temp_r     <= 7'(AMBIENT);
            cool_cnt_r <= 8'd0;
        end else if (load) begin
            temp_r     <= 7'(AMBIENT);
            cool_cnt_r <= 8'd0;
        end else if (tick) begin
            if (heat) begin
                temp_r     <= sat_add(temp_r, 7'(HEAT_STEP));
                cool_cnt_r <= 8'd0;
            end else if (cool_cnt_r == 8'(COOL_DIV - 1)) begin
                cool_cnt_r <= 8'd0;
                temp_r     <= (temp_r > 7'(AMBIENT)) ? temp_r - 7'd1 : 7'(AMBIENT);
            end else begin
                cool_cnt_r <= cool_cnt_r + 8'd1;
            end
        end
    end

    assign water_temp = temp_r;

endmodule

// File: rtl/wash_heater_ctrl.sv
// Wash heater controller: fill -> heat -> hold cycle driven by a one-hot
// temperature code. Optional heat timeout enabled by macro HEAT_TIMEOUT_EN.
module wash_heater_ctrl
    import wash_heater_ctrl_pkg::*;
#(
`ifdef HEAT_TIMEOUT_EN
    parameter int HEAT_MAX_TICKS = 64,
`endif
    parameter int AMBIENT    = 20,
    parameter int T_HOT      = 60,
    parameter int T_WARM     = 40,
    parameter int T_COLD     = 20,
    parameter int FILL_TICKS = 5,
    parameter int HOLD_TICKS = 10,
    parameter int HEAT_STEP  = 1,
    parameter int COOL_DIV   = 4,
    parameter int HYST       = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              start,
    input  logic              abort,
    input  logic [2:0]        temp_sel,
    output logic              valve_on,
    output logic              heater_on,
    output logic [TEMP_W-1:0] water_temp,
    output logic [2:0]        phase,
    output logic              busy,
    output logic              sel_en,
    output logic              done,
    output logic              fault
);

    logic [2:0]        phase_r, phase_n;
    logic [TEMP_W-1:0] target_r, target_n;
    logic [7:0]        cnt_r, cnt_n;
    logic              valve_r, valve_n;
    logic              heater_r, heater_n;
    logic              done_r, done_n;
    logic              fault_r, fault_n;
    logic              busy_r;
    logic              load_s;
    logic [TEMP_W-1:0] water_temp_s;
    logic [TEMP_W-1:0] heat_sum_s;

    wash_water_model #(
        .AMBIENT   (AMBIENT),
        .HEAT_STEP (HEAT_STEP),
        .COOL_DIV  (COOL_DIV)
    ) u_water (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .load       (load_s),
        .heat       (heater_r),
        .water_temp (water_temp_s)
    );

    // Value the water will reach on this tick while heating, for the HEAT exit test.
    assign heat_sum_s = sat_add(water_temp_s, 7'(HEAT_STEP));

    // Next-state and next-output logic; abort from any busy state overrides the rest.
    always_comb begin
        phase_n  = phase_r;
        target_n = target_r;
        cnt_n    = cnt_r;
        valve_n  = valve_r;
        heater_n = heater_r;
        done_n   = 1'b0;
        fault_n  = fault_r;
        load_s   = 1'b0;
        case (phase_r)
            PH_IDLE: begin
                valve_n  = 1'b0;
                heater_n = 1'b0;
                fault_n  = 1'b0;
                cnt_n    = 8'd0;
                if (start && !abort) begin
                    target_n = map_target(temp_sel, 7'(T_HOT), 7'(T_WARM), 7'(T_COLD));
                    phase_n  = PH_FILL;
                    valve_n  = 1'b1;
                    load_s   = 1'b1;
                end else begin
                    phase_n = PH_IDLE;
                end
            end
            PH_FILL: begin
                if (tick) begin
                    if (cnt_r == 8'(FILL_TICKS - 1)) begin
                        cnt_n   = 8'd0;
                        valve_n = 1'b0;
                        if (water_temp_s < target_r) begin
                            phase_n  = PH_HEAT;
                            heater_n = 1'b1;
                        end else begin
                            phase_n  = PH_HOLD;
                            heater_n = 1'b0;
                        end
                    end else begin
                        cnt_n = cnt_r + 8'd1;
                    end
                end else begin
                    cnt_n = cnt_r;
                end
            end
            PH_HEAT: begin
                if (tick) begin
                    if (heat_sum_s >= target_r) begin
                        phase_n  = PH_HOLD;
                        heater_n = 1'b0;
                        cnt_n    = 8'd0;
`ifdef HEAT_TIMEOUT_EN
                    end else if (cnt_r == 8'(HEAT_MAX_TICKS - 1)) begin
                        phase_n  = PH_FAULT;
                        heater_n = 1'b0;
                        fault_n  = 1'b1;
                        cnt_n    = 8'd0;
                    end else begin
                        cnt_n = cnt_r + 8'd1;
`else
                    end else begin
                        cnt_n = cnt_r;
`endif
                    end
                end else begin
                    cnt_n = cnt_r;
                end
            end
            PH_HOLD: begin
                if (({1'b0, water_temp_s} + 8'(HYST)) <= {1'b0, target_r}) begin
                    heater_n = 1'b1;
                end else if (water_temp_s >= target_r) begin
                    heater_n = 1'b0;
                end else begin
                    heater_n = heater_r;
                end
                if (tick) begin
                    if (cnt_r == 8'(HOLD_TICKS - 1)) begin
                        phase_n  = PH_DONE;
                        heater_n = 1'b0;
                        done_n   = 1'b1;
                        cnt_n    = 8'd0;
                    end else begin
                        cnt_n = cnt_r + 8'd1;
                    end
                end else begin
                    cnt_n = cnt_r;
                end
            end
            PH_DONE: begin
                phase_n = PH_IDLE;
            end
`ifdef HEAT_TIMEOUT_EN
            PH_FAULT: begin
                heater_n = 1'b0;
                valve_n  = 1'b0;
                fault_n  = 1'b1;
            end
`endif
            default: begin
                phase_n  = PH_IDLE;
                heater_n = 1'b0;
                valve_n  = 1'b0;
                fault_n  = 1'b0;
                cnt_n    = 8'd0;
            end
        endcase
        if (abort && (phase_r != PH_IDLE)) begin
            phase_n  = PH_IDLE;
            heater_n = 1'b0;
            valve_n  = 1'b0;
            done_n   = 1'b0;
            fault_n  = 1'b0;
            cnt_n    = 8'd0;
        end else begin
            phase_n = phase_n;
        end
    end

    // State, target latch, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_r  <= PH_IDLE;
            target_r <= 7'(T_WARM);
            cnt_r    <= 8'd0;
            valve_r  <= 1'b0;
            heater_r <= 1'b0;
            done_r   <= 1'b0;
            fault_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            phase_r  <= phase_n;
            target_r <= target_n;
            cnt_r    <= cnt_n;
            valve_r  <= valve_n;
            heater_r <= heater_n;
            done_r   <= done_n;
            fault_r  <= fault_n;
            busy_r   <= (phase_n != PH_IDLE);
        end
    end

    assign phase      = phase_r;
    assign valve_on   = valve_r;
    assign heater_on  = heater_r;
    assign water_temp = water_temp_s;
    assign busy       = busy_r;
    assign sel_en     = ~busy_r;
    assign done       = done_r;
    assign fault      = fault_r;

endmodule

// File: tb/tb_wash_heater_ctrl.sv
// Self-checking bench for wash_heater_ctrl: directed scenarios plus random
// stimulus, all compared against a behavioural reference model.
module tb_wash_heater_ctrl;

    localparam int AMB   = 20;
    localparam int MAX_T = 16;
`ifdef HEAT_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       tick;
    logic       start;
    logic       abort;
    logic [2:0] temp_sel;
    logic       valve_on;
    logic       heater_on;
    logic [6:0] water_temp;
    logic [2:0] phase;
    logic       busy;
    logic       sel_en;
    logic       done;
    logic       fault;

    int total;
    int bad;

    // reference model state
    int m_phase, m_temp, m_target, m_left, m_hticks, m_cool;
    bit m_valve, m_heater, m_done, m_fault;

`ifdef HEAT_TIMEOUT_EN
    wash_heater_ctrl #(.HEAT_MAX_TICKS(MAX_T)) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .abort(abort),
        .temp_sel(temp_sel), .valve_on(valve_on), .heater_on(heater_on),
        .water_temp(water_temp), .phase(phase), .busy(busy), .sel_en(sel_en),
        .done(done), .fault(fault)
    );
`else
    wash_heater_ctrl dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .abort(abort),
        .temp_sel(temp_sel), .valve_on(valve_on), .heater_on(heater_on),
        .water_temp(water_temp), .phase(phase), .busy(busy), .sel_en(sel_en),
        .done(done), .fault(fault)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int target_for(input logic [2:0] sel);
        case (sel)
            3'b001:  return 60;
            3'b010:  return 40;
            3'b100:  return 20;
            default: return 40;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_temp = AMB; m_target = 40; m_left = 0; m_hticks = 0; m_cool = 0;
        m_valve = 1'b0; m_heater = 1'b0; m_done = 1'b0; m_fault = 1'b0;
    endtask

    // One clock of the reference model, from the rules of the cycle.
    task automatic model_step(input bit t, input bit st, input bit ab, input logic [2:0] sel);
        int np, ntemp, ncool;
        bit nh, nv, nd, nf;
        np = m_phase; nh = m_heater; nv = m_valve; nd = 1'b0; nf = m_fault;
        ntemp = m_temp; ncool = m_cool;
        if (m_phase == 0 && st && !ab) begin
            ntemp = AMB; ncool = 0;
        end else if (t) begin
            if (m_heater) begin
                ntemp = (m_temp + 1 > 127) ? 127 : m_temp + 1;
                ncool = 0;
            end else begin
                ncool = m_cool + 1;
                if (ncool == 4) begin
                    ncool = 0;
                    if (m_temp > AMB) ntemp = m_temp - 1;
                end
            end
        end
        case (m_phase)
            0: if (st && !ab) begin
                m_target = target_for(sel); np = 1; m_left = 5; nv = 1'b1;
            end
            1: if (t) begin
                m_left--;
                if (m_left == 0) begin
                    nv = 1'b0;
                    if (m_temp < m_target) begin np = 2; nh = 1'b1; m_hticks = 0; end
                    else begin np = 3; nh = 1'b0; m_left = 10; end
                end
            end
            2: if (t) begin
                m_hticks++;
                if (ntemp >= m_target) begin np = 3; nh = 1'b0; m_left = 10; end
                else if (TIMEOUT_ON && m_hticks == MAX_T) begin np = 5; nh = 1'b0; nf = 1'b1; end
            end
            3: begin
                if (m_temp <= m_target - 2) nh = 1'b1;
                else if (m_temp >= m_target) nh = 1'b0;
                if (t) begin
                    m_left--;
                    if (m_left == 0) begin np = 4; nd = 1'b1; nh = 1'b0; end
                end
            end
            4: np = 0;
            default: ;
        endcase
        if (ab && m_phase != 0) begin
            np = 0; nh = 1'b0; nv = 1'b0; nd = 1'b0; nf = 1'b0;
        end
        m_phase = np; m_heater = nh; m_valve = nv; m_done = nd; m_fault = nf;
        m_temp = ntemp; m_cool = ncool;
    endtask

    task automatic full_check(input string tag);
        chk({tag, ".phase"},  32'(phase),      32'(m_phase));
        chk({tag, ".temp"},   32'(water_temp), 32'(m_temp));
        chk({tag, ".valve"},  32'(valve_on),   32'(m_valve));
        chk({tag, ".heater"}, 32'(heater_on),  32'(m_heater));
        chk({tag, ".busy"},   32'(busy),       32'(m_phase != 0));
        chk({tag, ".sel_en"}, 32'(sel_en),     32'(m_phase == 0));
        chk({tag, ".done"},   32'(done),       32'(m_done));
        chk({tag, ".fault"},  32'(fault),      32'(m_fault));
    endtask

    task automatic step(input string tag, input bit t, input bit st, input bit ab, input logic [2:0] sel);
        tick = t; start = st; abort = ab; temp_sel = sel;
        model_step(t, st, ab, sel);
        @(posedge clk); #1;
        tick = 1'b0; start = 1'b0; abort = 1'b0;
        full_check(tag);
    endtask

    initial begin
        int n_fill, n_heat, n_hold, n_done, n_ticks, p;
        bit heater_seen;
        total = 0; bad = 0;
        reset = 1'b0; tick = 1'b0; start = 1'b0; abort = 1'b0; temp_sel = 3'b001;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        full_check("reset");
        reset = 1'b1;
        step("idle", 1'b0, 1'b0, 1'b0, 3'b001);

        // hot cycle, tick every cycle
        step("hot_start", 1'b0, 1'b1, 1'b0, 3'b001);
        n_fill = 0; n_heat = 0; n_hold = 0; n_done = 0;
        for (int i = 0; i < 200 && phase != 3'd0; i++) begin
            p = int'(phase);
            step("hot", 1'b1, 1'b0, 1'b0, 3'b001);
            if (p == 1) n_fill++;
            if (p == 2) n_heat++;
            if (p == 3) n_hold++;
            if (done) n_done++;
        end
        chk("hot_fill_ticks", n_fill, 5);
        chk("hot_heat_ticks", n_heat, 40);
        chk("hot_hold_ticks", n_hold, 10);
        chk("hot_done_pulses", n_done, 1);
        chk("hot_end_phase", 32'(phase), 0);
        chk("hot_end_sel_en", 32'(sel_en), 1);

        // cold cycle: straight to HOLD, no heating
        step("cold_start", 1'b0, 1'b1, 1'b0, 3'b100);
        n_ticks = 0; heater_seen = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            step("cold", 1'b1, 1'b0, 1'b0, 3'b100);
            n_ticks++;
            heater_seen |= heater_on;
        end
        chk("cold_ticks_to_done", n_ticks, 15);
        chk("cold_heater_seen", 32'(heater_seen), 0);
        step("cold_back", 1'b0, 1'b0, 1'b0, 3'b100);
        chk("cold_idle", 32'(phase), 0);

        // abort at HEAT tick 10, then IDLE cooling
        step("ab_start", 1'b0, 1'b1, 1'b0, 3'b001);
        for (int i = 0; i < 20 && phase != 3'd2; i++) step("ab_fill", 1'b1, 1'b0, 1'b0, 3'b001);
        for (int i = 0; i < 10; i++) step("ab_heat", 1'b1, 1'b0, 1'b0, 3'b001);
        chk("ab_temp_before", 32'(water_temp), 30);
        step("ab_abort", 1'b0, 1'b0, 1'b1, 3'b001);
        chk("ab_phase", 32'(phase), 0);
        chk("ab_heater", 32'(heater_on), 0);
        chk("ab_temp_kept", 32'(water_temp), 30);
        chk("ab_no_done", 32'(done), 0);
        for (int i = 0; i < 39; i++) step("ab_cool", 1'b1, 1'b0, 1'b0, 3'b001);
        chk("ab_cool_39", 32'(water_temp), 21);
        step("ab_cool", 1'b1, 1'b0, 1'b0, 3'b001);
        chk("ab_cool_40", 32'(water_temp), 20);

        // illegal code 011 -> warm target
        step("ill_start", 1'b0, 1'b1, 1'b0, 3'b011);
        for (int i = 0; i < 100 && phase != 3'd3; i++) step("ill", 1'b1, 1'b0, 1'b0, 3'b011);
        chk("ill_phase_hold", 32'(phase), 3);
        chk("ill_exit_temp", 32'(water_temp), 40);
        step("ill_abort", 1'b0, 1'b0, 1'b1, 3'b011);

        // start and temp_sel changes ignored during HOLD
        step("ign_start", 1'b0, 1'b1, 1'b0, 3'b100);
        for (int i = 0; i < 5; i++) step("ign_fill", 1'b1, 1'b0, 1'b0, 3'b100);
        chk("ign_in_hold", 32'(phase), 3);
        for (int i = 0; i < 9; i++) step("ign_hold", 1'b1, 1'b1, 1'b0, 3'b001);
        chk("ign_still_hold", 32'(phase), 3);
        chk("ign_heater_off", 32'(heater_on), 0);
        step("ign_last", 1'b1, 1'b1, 1'b0, 3'b001);
        chk("ign_done_phase", 32'(phase), 4);
        chk("ign_done", 32'(done), 1);
        step("ign_back", 1'b0, 1'b0, 1'b0, 3'b001);
        step("st_ab_idle", 1'b0, 1'b1, 1'b1, 3'b001);
        chk("st_ab_phase", 32'(phase), 0);

`ifdef HEAT_TIMEOUT_EN
        // heat timeout into FAULT, left only by abort
        step("to_start", 1'b0, 1'b1, 1'b0, 3'b001);
        for (int i = 0; i < 5 + MAX_T; i++) step("to_run", 1'b1, 1'b0, 1'b0, 3'b001);
        chk("to_phase", 32'(phase), 5);
        chk("to_fault", 32'(fault), 1);
        chk("to_heater", 32'(heater_on), 0);
        for (int i = 0; i < 3; i++) step("to_stay", 1'b1, 1'b1, 1'b0, 3'b001);
        step("to_abort", 1'b0, 1'b0, 1'b1, 3'b001);
        chk("to_abort_phase", 32'(phase), 0);
        chk("to_abort_fault", 32'(fault), 0);
`endif

        // asynchronous reset in the middle of a heat phase
        step("rst_start", 1'b0, 1'b1, 1'b0, 3'b001);
        for (int i = 0; i < 8; i++) step("rst_run", 1'b1, 1'b0, 1'b0, 3'b001);
        #3 reset = 1'b0;
        #1;
        model_reset();
        full_check("async_reset");
        @(posedge clk); #1;
        reset = 1'b1;

        // random stimulus against the model
        for (int i = 0; i < 1500; i++) begin
            step("rand",
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 59) == 0),
                 3'($urandom_range(0, 7)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wash_heater_ctrl.md
Name: wash_heater_ctrl

Overview:
Downstream consumer of the wash temperature selector. Takes the 3-bit one-hot temperature code (001 hot, 010 warm, 100 cold) and a start pulse, then runs fill → heat → hold. Drives the water valve and heater, and models water temperature with a tick-driven accumulator. Exports sel_en so the selector is frozen while a cycle is running.

Parameters:
AMBIENT, 20, water temperature after fill and the cooling floor (°C)
T_HOT, 60, target for temp_sel 001
T_WARM, 40, target for temp_sel 010 and for any illegal code
T_COLD, 20, target for temp_sel 100
FILL_TICKS, 5, ticks spent in FILL
HOLD_TICKS, 10, ticks spent in HOLD
HEAT_STEP, 1, °C added per tick while the heater is on
COOL_DIV, 4, ticks per 1 °C drop while the heater is off
HYST, 2, HOLD re-heat threshold below the target
HEAT_MAX_TICKS, 64, HEAT timeout; used only with the optional feature

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low
tick  in  1  one-cycle time-base enable
start  in  1  one-cycle request to begin a cycle
abort  in  1  one-cycle cancel request
temp_sel  in  3  one-hot temperature code from the selector
valve_on  out  1  fill valve drive
heater_on  out  1  heater drive
water_temp  out  7  modelled water temperature, °C, unsigned
phase  out  3  current state encoding
busy  out  1  high in every state except IDLE
sel_en  out  1  equals ~busy; feeds the selector's enable
done  out  1  one-cycle pulse when a cycle completes
fault  out  1  heat-timeout flag; tied to 0 without the optional feature

Behaviour:
- Reset values: phase=IDLE, water_temp=AMBIENT, valve_on=0, heater_on=0, busy=0, sel_en=1, done=0, fault=0, all counters=0.
- Phase encoding: IDLE=0, FILL=1, HEAT=2, HOLD=3, DONE=4, FAULT=5.
- IDLE:
  - start=1 latches temp_sel as target (illegal code → T_WARM) and moves to FILL on the next clk.
  - If start and abort are both 1 in the same cycle, abort wins and the block stays in IDLE.
- FILL:
  - valve_on=1.
  - water_temp is loaded with AMBIENT on entry.
  - After FILL_TICKS ticks: go to HEAT if water_temp < target, otherwise go to HOLD.
- HEAT:
  - heater_on=1.
  - Each tick, water_temp += HEAT_STEP, saturating at 127.
  - Go to HOLD on the tick where the updated value is ≥ target.
- HOLD:
  - Runs for HOLD_TICKS ticks.
  - Heater turns on when water_temp ≤ target−HYST and off when water_temp ≥ target.
  - While the heater is on, HEAT_STEP is added per tick.
  - While the heater is off, water_temp drops 1 every COOL_DIV ticks, never below AMBIENT.
  - Then go to DONE.
- DONE: done=1 for exactly one clk, then IDLE.
- Outputs are registered and follow the current state; valve_on and heater_on are never both 1.
- Cooling in IDLE: 1 °C per COOL_DIV ticks, floored at AMBIENT.
- abort in any state other than IDLE:
  - Next clk goes to IDLE with heater_on and valve_on cleared.
  - done is not pulsed; water_temp is retained.
- start while busy is ignored.
- temp_sel changes while busy are ignored; the target stays latched.
- Asynchronous reset mid-cycle returns all outputs to their reset values immediately.
- Without tick, no counter, temperature or tick-driven transition advances. Exceptions: abort, the DONE→IDLE return and the IDLE start are all clk-driven.

Optional Feature:
HEAT_TIMEOUT_EN
- Defined:
  - The HEAT state counts ticks.
  - On reaching HEAT_MAX_TICKS with target not yet reached, go to FAULT.
  - FAULT: heater_on=0, valve_on=0, fault=1, busy=1. It is left only through abort or reset, both returning to IDLE with fault=0.
- Undefined: no FAULT state, no timeout counter, fault tied to 0.

Decomposition:
- Shared package:
  - phase encodings
  - temp_sel one-hot codes
  - target-mapping function (code → °C, illegal → T_WARM)
  - the 7-bit temperature width constant
- One sub-module, wash_water_model:
  - holds the water_temp accumulator and the COOL_DIV prescaler
  - inputs: load, heat, tick
  - applies saturation and the floor
- The main block keeps the FSM, the tick counters and the target latch.

Test Plan:
- Hot cycle (tick every cycle): temp_sel=001, start.
  - FILL lasts 5 ticks; HEAT lasts 40 ticks (water_temp 20→60); HOLD lasts 10 ticks.
  - done pulses once; phase returns to 0; sel_en=1.
- Cold cycle: temp_sel=100, start → FILL then straight to HOLD; heater_on is never 1; done after 15 ticks.
- Abort at HEAT tick 10 (water_temp=30):
  - Next clk: phase=0, heater_on=0, water_temp=30, no done.
  - Then water_temp decays to 20 over 40 ticks.
- Illegal temp_sel=011 → target 40; HEAT exits at water_temp=40.
- Ignored inputs while busy: start and temp_sel changes during HOLD have no effect; start+abort together in IDLE keeps phase=0.
- HEAT_TIMEOUT_EN with HEAT_MAX_TICKS=16 and temp_sel=001:
  - After 16 HEAT ticks: phase=5, fault=1, heater_on=0.
  - abort → phase=0, fault=0.
